axis_rs232tx_arbiter: RTL

- Round-robin arbiter that shares one byte-wide AXI-stream transmit path among CHANNELS byte-stream requesters.
- Output connects directly to the UART transmitter's idata/ivalid/iready interface.
- A grant is held for one packet, closed by ilast, or until MAX_BURST bytes have passed. This stops one requester from starving the others on the slow serial line.
- Output is a one-entry register stage.

---
 rtl/axis_rs232tx_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/axis_rs232tx_arbiter.sv
// axis_rs232tx_arbiter: round-robin arbiter sharing one registered byte stream among CHANNELS requesters.
// Optional AXIS_RS232TX_ARBITER_TAG_EN prefixes each grant with a tag byte 8'hF0|owner.
module axis_rs232tx_arbiter #(
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [8*CHANNELS-1:0] idata,
  input  logic [CHANNELS-1:0]   ivalid,
  input  logic [CHANNELS-1:0]   ilast,
  output logic [CHANNELS-1:0]   iready,
  output logic [7:0]            odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [CHANNELS-1:0]   grant
);
  localparam int IW = $clog2(CHANNELS);
`ifdef AXIS_RS232TX_ARBITER_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, PASS} state_t;
`else
  typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif
  state_t state, state_nx;
  logic [IW-1:0] gidx, last, sel, c;
  logic sel_ok, take, xfer, done;
  logic [7:0] count;
  // Scan downwards so the nearest requester after the last owner overwrites the rest.
  always_comb begin
    sel = '0;
    sel_ok = 1'b0;
    c = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      c = IW'((int'(last) + k) % CHANNELS);
      if (ivalid[c]) begin
        sel = c;
        sel_ok = 1'b1;
      end
    end
  end
  assign take = !ovalid || oready;
  assign xfer = (state == PASS) && take && ivalid[gidx];
  assign done = xfer && (ilast[gidx] || count == 8'(MAX_BURST - 1));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
`ifdef AXIS_RS232TX_ARBITER_TAG_EN
    state_nx = state == IDLE ? (sel_ok ? TAG : IDLE) :
               state == TAG  ? (take ? PASS : TAG) :
               (done ? IDLE : PASS);
`else
    state_nx = state == IDLE ? (sel_ok ? PASS : IDLE) : (done ? IDLE : PASS);
`endif
  end
  always_comb iready = (state == PASS && take) ? grant : '0;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      grant  <= '0;
      gidx   <= '0;
      last   <= IW'(CHANNELS - 1);
      count  <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else begin
      if (state == IDLE && sel_ok) begin
        grant <= CHANNELS'(1) << sel;
        gidx  <= sel;
        count <= '0;
      end
      if (xfer) count <= count + 8'd1;
      if (done) begin
        grant <= '0;
        last  <= gidx;
      end
      if (xfer) begin
        odata  <= idata[8*gidx +: 8];
        ovalid <= 1'b1;
      end
`ifdef AXIS_RS232TX_ARBITER_TAG_EN
      else if (state == TAG && take) begin
        odata  <= 8'hF0 | 8'(gidx);
        ovalid <= 1'b1;
      end
`endif
      else if (oready) ovalid <= 1'b0;
    end
endmodule
